// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system definitions: arbiter state encoding, requester IDs
// and default block-address / line widths used by both caches and the arbiter.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

  function automatic arb_state_e grant_state(input requester_e who);
    arb_state_e st;
    st = ARB_GRANT_I;
    if (who == REQ_D) st = ARB_GRANT_D;
    return st;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_grant2.sv
// Two-way round-robin decision: a lone requester wins outright; on a tie the
// requester that was not served last wins.
module rr_grant2
  import mem_arbiter_pkg::*;
(
  input  logic       icache_req_i,
  input  logic       dcache_req_i,
  input  requester_e last_i,
  output logic       valid_o,
  output requester_e grant_o
);

  always_comb begin
    valid_o = icache_req_i | dcache_req_i;
    grant_o = REQ_I;
    if (dcache_req_i && (!icache_req_i || (last_i == REQ_I))) begin
      grant_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared line-wide memory port between the instruction and data
// caches; commands to memory are captured at grant time and held until mem_ready.
//
//   state    | meaning
//   IDLE     | no transaction; pick a requester via round-robin
//   GRANT_I  | instruction-cache command on mem_*, waiting for mem_ready
//   GRANT_D  | data-cache command on mem_*, waiting for mem_ready
//   RELEASE  | one dead cycle so the served cache can drop its request
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,

  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  requester_e        last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              i_active, d_active;
  logic              req_valid;
  requester_e        req_grant;

  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign i_active = i_read | i_write;
  assign d_active = d_read | d_write;

  rr_grant2 u_rr_grant2 (
    .icache_req_i (i_active),
    .dcache_req_i (d_active),
    .last_i       (last_grant_q),
    .valid_o      (req_valid),
    .grant_o      (req_grant)
  );

  always_comb begin
    if (req_grant == REQ_D) begin
      sel_read  = d_read;
      sel_write = d_write;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else begin
      sel_read  = i_read;
      sel_write = i_write;
      sel_addr  = i_addr;
      sel_wdata = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (req_valid) state_d = grant_state(req_grant);
      ARB_GRANT_I: if (mem_ready) state_d = ARB_RELEASE;
      ARB_GRANT_D: if (mem_ready) state_d = ARB_RELEASE;
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Write wins when a cache raises read and write together.
  always_comb begin
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_valid) begin
          mem_write_d = sel_write;
          mem_read_d  = sel_read & ~sel_write;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ARB_GRANT_I: begin
        if (mem_ready) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = REQ_I;
        end
      end
      ARB_GRANT_D: begin
        if (mem_ready) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = REQ_D;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      last_grant_q <= REQ_I;
    end else begin
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Ready is masked while reset is asserted so an in-flight grant cannot leak a pulse.
  always_comb begin
    i_ready = ~proc_reset & mem_ready & (state_q == ARB_GRANT_I);
    d_ready = ~proc_reset & mem_ready & (state_q == ARB_GRANT_D);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected grants,
// a negedge monitor pops and checks whenever a cache ready pulse appears.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_ready, d_ready;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          is_d;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_ready    (i_ready),
    .i_rdata    (i_rdata),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rdata    (d_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic is_d, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [DW-1:0] rdata);
    exp_t e;
    e.is_d = is_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  // Monitor: every ready pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (i_ready || d_ready) begin
      if (i_ready && d_ready) begin
        chk("both_ready", {i_ready, d_ready}, 2'b00);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_ready", {i_ready, d_ready}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_owner", d_ready, e.is_d);
        chk("mem_read_at_ready", mem_read, e.rd);
        chk("mem_write_at_ready", mem_write, e.wr);
        chk("mem_addr_at_ready", mem_addr, e.addr);
        chk("mem_wdata_at_ready", mem_wdata, e.wdata);
        chk("rdata_at_ready", d_ready ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd();
    int k = 0;
    while (!(mem_read || mem_write) && k < 50) begin
      cyc(1);
      k++;
    end
    chk("cmd_seen", mem_read || mem_write, 1'b1);
  endtask

  task automatic pulse_ready(input logic [DW-1:0] rd);
    mem_rdata = rd;
    mem_ready = 1'b1;
    cyc(1);
    mem_ready = 1'b0;
  endtask

  task automatic serve(input int lat, input logic [DW-1:0] rd);
    wait_cmd();
    if (lat > 1) cyc(lat - 1);
    pulse_ready(rd);
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    cyc(2);
    proc_reset = 1'b0;
    cyc(1);
  endtask

  localparam logic [DW-1:0] R0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DW-1:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] R2 = 128'hdead_beef_0000_0001_cafe_f00d_0000_0002;
  localparam logic [DW-1:0] W1 = 128'haaaa_0000_bbbb_0000_cccc_0000_dddd_0001;
  localparam logic [DW-1:0] W2 = 128'h5555_6666_7777_8888_9999_aaaa_bbbb_cccc;
  localparam logic [DW-1:0] W3 = 128'h0f0f_0f0f_f0f0_f0f0_1234_5678_9abc_def0;

  initial begin
    proc_reset = 1'b1;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    cyc(2);
    chk("rst_i_ready", i_ready, 1'b0);
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    proc_reset = 1'b0;
    cyc(1);
    chk("post_rst_ready", {i_ready, d_ready}, 2'b00);

    // Single i-cache read, memory answers 5 cycles after the request.
    i_read = 1; i_addr = 28'h0000010;
    push(1'b0, 1'b1, 1'b0, 28'h0000010, '0, R0);
    chk("latency_before_edge", mem_read, 1'b0);
    cyc(1);
    chk("latency_mem_read", mem_read, 1'b1);
    chk("latency_mem_addr", mem_addr, 28'h0000010);
    cyc(3);
    pulse_ready(R0);
    i_read = 0;
    chk("cmd_cleared", {mem_read, mem_write}, 2'b00);
    cyc(3);

    // Simultaneous requests after reset: D wins first, then I.
    do_reset();
    i_read = 1; i_addr = 28'h0000040;
    d_write = 1; d_addr = 28'h0000050; d_wdata = W1;
    push(1'b1, 1'b0, 1'b1, 28'h0000050, W1, R1);
    push(1'b0, 1'b1, 1'b0, 28'h0000040, '0, R2);
    serve(2, R1);
    d_write = 0;
    serve(2, R2);
    i_read = 0;
    cyc(2);

    // Both held for four transactions: D, I, D, I.
    d_read = 1; d_addr = 28'h0000100; d_wdata = '0;
    i_read = 1; i_addr = 28'h0000200;
    push(1'b1, 1'b1, 1'b0, 28'h0000100, '0, R0);
    push(1'b0, 1'b1, 1'b0, 28'h0000200, '0, R1);
    push(1'b1, 1'b1, 1'b0, 28'h0000100, '0, R2);
    push(1'b0, 1'b1, 1'b0, 28'h0000200, '0, R0);
    serve(1, R0);
    serve(3, R1);
    serve(2, R2);
    serve(1, R0);
    d_read = 0; i_read = 0;
    cyc(2);

    // Requester inputs change mid-grant; memory command must hold.
    d_read = 1; d_addr = 28'h0000020; d_wdata = W2;
    push(1'b1, 1'b1, 1'b0, 28'h0000020, W2, R1);
    wait_cmd();
    d_addr = 28'h0000030; d_wdata = W3;
    cyc(1);
    chk("hold_addr_1", mem_addr, 28'h0000020);
    cyc(1);
    chk("hold_addr_2", mem_addr, 28'h0000020);
    chk("hold_wdata", mem_wdata, W2);
    pulse_ready(R1);
    d_read = 0;
    cyc(2);

    // Read and write together: write forwarded, read dropped.
    d_read = 1; d_write = 1; d_addr = 28'h0000060; d_wdata = W3;
    push(1'b1, 1'b0, 1'b1, 28'h0000060, W3, R2);
    wait_cmd();
    chk("rw_mem_write", mem_write, 1'b1);
    chk("rw_mem_read", mem_read, 1'b0);
    cyc(1);
    pulse_ready(R2);
    d_read = 0; d_write = 0;
    cyc(2);

    // Reset during GRANT_I, with mem_ready during and after reset.
    i_read = 1; i_addr = 28'h0000070; i_wdata = W1;
    wait_cmd();
    cyc(1);
    proc_reset = 1; i_read = 0; mem_ready = 1; mem_rdata = R0;
    #1;
    chk("rst_mid_ready", {i_ready, d_ready}, 2'b00);
    cyc(1);
    proc_reset = 0;
    chk("rst_mid_mem_cmd", {mem_read, mem_write}, 2'b00);
    chk("rst_mid_mem_addr", mem_addr, '0);
    chk("rst_mid_mem_wdata", mem_wdata, '0);
    cyc(1);
    chk("stray_ready_ignored", {i_ready, d_ready}, 2'b00);
    chk("stray_mem_cmd", {mem_read, mem_write}, 2'b00);
    mem_ready = 0;
    cyc(1);

    // last_grant back to I after reset: a tie goes to D first.
    i_read = 1; i_addr = 28'h0000080;
    d_read = 1; d_addr = 28'h0000090; d_wdata = '0; i_wdata = '0;
    push(1'b1, 1'b1, 1'b0, 28'h0000090, '0, R2);
    push(1'b0, 1'b1, 1'b0, 28'h0000080, '0, R1);
    serve(1, R2);
    d_read = 0;
    serve(2, R1);
    i_read = 0;
    cyc(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
